ip_arbiter_n: RTL
=================

IP_ARBITER_N -- requirements
Module: ip_arbiter_n

Interface
REQ-001 Parameter NUM_SLV, default 4: number of slave (source) channels, legal 2..16.
REQ-002 Parameter DW, default 32: pixel data width.
REQ-003 Parameter MODE_W, default 2: per-channel mode width; a mode value of 0 means the channel is inactive.
REQ-004 Parameter MAX_BURST, default 16: maximum beats per grant in round-robin policy before re-arbitration.
REQ-005 Parameter DRAIN_CYCLES, default 2: minimum wait cycles after proc_cmplt before completion.
REQ-006 Ports, in order (name, direction, width, meaning):
- clk, in, 1: single clock; all logic on rising edge.
- rst, in, 1: reset, synchronous, active-high.
- arb_policy, in, 1: 0 = fixed priority (lowest index wins); 1 = round-robin.
- slv_mode, in, NUM_SLV x MODE_W: per-channel mode; nonzero means the channel is requesting.
- slv_data_valid, in, NUM_SLV: per-channel data valid.
- slv_proc_valid, in, NUM_SLV: per-channel process-valid flag.
- slv_data, in, NUM_SLV x DW: per-channel data.
- slv_ready, out, NUM_SLV: per-channel ready; one-hot or zero.
- fifo_full, in, 1: downstream FIFO full.
- fifo_empty, in, 1: downstream FIFO empty.
- proc_cmplt, in, 1: processing-complete request.
- slvx_mode, out, MODE_W: muxed mode.
- slvx_data_valid, out, 1: muxed valid.
- slvx_proc_val, out, 1: muxed process-valid.
- slvx_data, out, DW: muxed data.
- data_source, out, $clog2(NUM_SLV): index of the granted channel.
- mstr_cmplt, out, 1: one-cycle completion pulse.

Function
REQ-007 The FSM SHALL have four states (IDLE, GRANT, DRAIN, DONE); after reset it SHALL be in IDLE.
REQ-008 IDLE: if any channel is requesting and fifo_full=0 and proc_cmplt=0, the block SHALL select a winner per arb_policy, load data_source, clear the beat counter and enter GRANT on the next cycle.
REQ-009 Round-robin SHALL search starting at (last grant + 1) mod NUM_SLV; fixed priority SHALL search from index 0.
REQ-010 slv_ready[data_source] SHALL be combinational: state==GRANT && !fifo_full && !proc_cmplt. All other slv_ready bits SHALL be 0.
REQ-011 A beat SHALL be transferred when slv_ready[i] && slv_data_valid[i].
REQ-012 On a beat, slvx_data, slvx_mode and slvx_proc_val SHALL register the channel's values and slvx_data_valid SHALL be 1 on the next cycle (latency 1).
REQ-013 With no beat, slvx_data_valid SHALL be 0 and slvx_data/slvx_mode/slvx_proc_val SHALL hold their values.
REQ-014 The beat counter SHALL increment on each beat and saturate at MAX_BURST.
REQ-015 In GRANT, re-arbitration SHALL occur (same cycle, FSM stays in GRANT) if slv_mode[data_source]==0, or if arb_policy=1, the counter is at MAX_BURST and another channel is requesting.
REQ-016 In GRANT, if no channel is requesting, the FSM SHALL return to IDLE.
REQ-017 fifo_full=1 SHALL only stall transfers (ready low); it SHALL NOT alter the grant or the counter.
REQ-018 proc_cmplt=1 in IDLE or GRANT SHALL move the FSM to DRAIN and load the drain counter with DRAIN_CYCLES. If a beat coincides with proc_cmplt, proc_cmplt wins and no beat occurs.
REQ-019 In DRAIN, slvx_mode, slvx_proc_val and slvx_data_valid SHALL be 0. The drain counter SHALL decrement to 0. When the counter is 0 and fifo_empty=1, the FSM SHALL go to DONE.
REQ-020 In DRAIN, proc_cmplt SHALL be ignored.
REQ-021 DONE SHALL last one cycle: mstr_cmplt=1, data_source reset to 0, round-robin pointer reset to NUM_SLV-1, then IDLE.

Reset
REQ-022 On rst=1 at a clock edge, all outputs SHALL be 0, the FSM SHALL be in IDLE, all counters SHALL be 0 and the round-robin pointer SHALL be NUM_SLV-1.
REQ-023 Reset SHALL abort any state, including mid-burst and mid-drain, with no mstr_cmplt pulse.

Structure
REQ-024 Package ip_arb_pkg SHALL hold the state enum arb_state_t and the policy constants ARB_FIXED and ARB_RR.
REQ-025 Winner selection SHALL be one sub-module, rr_pick (request vector + start pointer in, index + found out), reused for both policies.

Verification
REQ-026 Fixed priority: ch1 and ch2 both requesting with valid data continuously -> only ch1 is granted; data_source=1 and slvx_data follows ch1 data one cycle later.
REQ-027 Round-robin with MAX_BURST=4, all four channels valid -> grants rotate 0,1,2,3,0 with exactly 4 beats each.
REQ-028 fifo_full held 3 cycles mid-burst -> slv_ready=0 and slvx_data_valid=0 for those cycles; resumes with the same data_source and no beat lost.
REQ-029 proc_cmplt pulsed with fifo_empty=0 for 5 further cycles -> mstr_cmplt pulses exactly once, in the cycle after fifo_empty rises (at least DRAIN_CYCLES+1 cycles after proc_cmplt); data_source=0.
REQ-030 Granted channel's mode drops to 0 while ch3 is requesting -> the same cycle switches data_source to 3 with no spurious slvx_data_valid.
REQ-031 rst asserted mid-drain -> next cycle all outputs are 0 and no mstr_cmplt pulse occurs.

Source files
------------

// File: rtl/ip_arb_pkg.sv
// Shared types for the N-channel arbiter: FSM state encoding and arbitration policy values.
package ip_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

endpackage

// File: rtl/ip_arbiter_n_rr_pick.sv
// Circular winner search: first requester at or after start_i, wrapping at N.
// Fixed priority uses start_i = 0, round-robin uses last grant + 1.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  logic [IW:0] pos_w;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    pos_w   = '0;
    // Offsets are walked high-to-low so the nearest requester after start_i is written last.
    for (int k = N - 1; k >= 0; k--) begin
      pos_w = {1'b0, start_i} + (IW + 1)'(k);
      if (pos_w >= (IW + 1)'(N)) begin
        pos_w = pos_w - (IW + 1)'(N);
      end
      if (req_i[pos_w[IW-1:0]]) begin
        idx_o   = pos_w[IW-1:0];
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ip_arbiter_n.sv
// N-channel pixel-stream arbiter: fixed-priority or round-robin grant with a burst limit,
// a registered output mux and a drain/complete handshake towards the downstream FIFO.
module ip_arbiter_n
  import ip_arb_pkg::*;
#(
  parameter int NUM_SLV      = 4,
  parameter int DW           = 32,
  parameter int MODE_W       = 2,
  parameter int MAX_BURST    = 16,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arb_policy,
  input  logic [NUM_SLV*MODE_W-1:0]  slv_mode,
  input  logic [NUM_SLV-1:0]         slv_data_valid,
  input  logic [NUM_SLV-1:0]         slv_proc_valid,
  input  logic [NUM_SLV*DW-1:0]      slv_data,
  output logic [NUM_SLV-1:0]         slv_ready,
  input  logic                       fifo_full,
  input  logic                       fifo_empty,
  input  logic                       proc_cmplt,
  output logic [MODE_W-1:0]          slvx_mode,
  output logic                       slvx_data_valid,
  output logic                       slvx_proc_val,
  output logic [DW-1:0]              slvx_data,
  output logic [$clog2(NUM_SLV)-1:0] data_source,
  output logic                       mstr_cmplt
);

  localparam int IW  = $clog2(NUM_SLV);
  localparam int CW  = $clog2(MAX_BURST + 1);
  localparam int DCW = $clog2(DRAIN_CYCLES + 2);
  localparam logic [IW-1:0]  LAST_IDX   = IW'(NUM_SLV - 1);
  localparam logic [CW-1:0]  BURST_MAX  = CW'(MAX_BURST);
  localparam logic [DCW-1:0] DRAIN_INIT = DCW'(DRAIN_CYCLES);

  arb_state_t        state_q, state_d;
  logic [IW-1:0]     src_q, src_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [DCW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [DW-1:0]     data_q, data_d;
  logic              dvalid_q, dvalid_d;
  logic              pval_q, pval_d;

  logic [MODE_W-1:0]  mode_arr [NUM_SLV];
  logic [DW-1:0]      data_arr [NUM_SLV];
  logic [NUM_SLV-1:0] req;
  logic [NUM_SLV-1:0] src_hot;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLV; gi++) begin : g_chan
      assign mode_arr[gi] = slv_mode[gi*MODE_W +: MODE_W];
      assign data_arr[gi] = slv_data[gi*DW +: DW];
      assign req[gi]      = |slv_mode[gi*MODE_W +: MODE_W];
      assign src_hot[gi]  = (src_q == IW'(gi));
    end
  endgenerate

  logic          any_req, other_req, burst_done, rearb, xfer_en, beat;
  logic [IW-1:0] pick_start, pick_idx;
  logic          pick_found;

  assign any_req    = |req;
  assign other_req  = |(req & ~src_hot);
  assign burst_done = (arb_policy == ARB_RR) && (beat_cnt_q == BURST_MAX) && other_req;
  // A grant that is about to be re-arbitrated must not move data in the same cycle.
  assign rearb      = (mode_arr[src_q] == '0) || burst_done;
  assign xfer_en    = (state_q == GRANT) && !fifo_full && !proc_cmplt && any_req && !rearb;
  assign slv_ready  = xfer_en ? src_hot : '0;
  assign beat       = xfer_en && slv_data_valid[src_q];
  assign pick_start = (arb_policy == ARB_RR) ? ((ptr_q == LAST_IDX) ? '0 : ptr_q + 1'b1) : '0;

  rr_pick #(
    .N  (NUM_SLV),
    .IW (IW)
  ) u_pick (
    .req_i   (req),
    .start_i (pick_start),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    ptr_d       = ptr_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    mode_d      = mode_q;
    data_d      = data_q;
    pval_d      = pval_q;
    dvalid_d    = 1'b0;
    case (state_q)
      IDLE, GRANT: begin
        if (proc_cmplt) begin
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_INIT;
          mode_d      = '0;
          pval_d      = 1'b0;
        end else if (state_q == IDLE) begin
          if (!fifo_full && pick_found) begin
            state_d    = GRANT;
            src_d      = pick_idx;
            ptr_d      = pick_idx;
            beat_cnt_d = '0;
          end
        end else if (!any_req) begin
          state_d = IDLE;
        end else if (!fifo_full && rearb) begin
          src_d      = pick_idx;
          ptr_d      = pick_idx;
          beat_cnt_d = '0;
        end else if (beat) begin
          mode_d   = mode_arr[src_q];
          data_d   = data_arr[src_q];
          pval_d   = slv_proc_valid[src_q];
          dvalid_d = 1'b1;
          if (beat_cnt_q != BURST_MAX) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt_q != '0) begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end else if (fifo_empty) begin
          state_d = DONE;
          src_d   = '0;
          ptr_d   = LAST_IDX;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= '0;
      ptr_q       <= LAST_IDX;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      mode_q      <= '0;
      data_q      <= '0;
      dvalid_q    <= 1'b0;
      pval_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      ptr_q       <= ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      mode_q      <= mode_d;
      data_q      <= data_d;
      dvalid_q    <= dvalid_d;
      pval_q      <= pval_d;
    end
  end

  assign slvx_mode       = mode_q;
  assign slvx_data       = data_q;
  assign slvx_data_valid = dvalid_q;
  assign slvx_proc_val   = pval_q;
  assign data_source     = src_q;
  assign mstr_cmplt      = (state_q == DONE);

endmodule
